// File: rtl/sw_debounce_pkg.sv
// Shared constants for the switch debouncer and the switch bus controller.
package sw_debounce_pkg;

  localparam int SW_WIDTH_DEFAULT        = 16;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 100000;

  // Counter width able to hold 0..cycles-1. A floor of 1 bit keeps the
  // vector legal for the smallest allowed cycle count.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// Single-channel debouncer: two-flop synchronizer, stability counter,
// accepted-level flop, and a combinational accept strobe for the parent.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o,
  output logic accept_o
);

  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             stable_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             mismatch;

  // Bring the asynchronous switch level into the clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= raw_i;
      sync2_reg <= sync1_reg;
    end
  end

  // Count consecutive disagreements; accept the new level once the count
  // has reached its ceiling, so the counter can never wrap.
  always_comb begin
    mismatch    = sync2_reg ^ stable_reg;
    accept_o    = mismatch && (cnt_reg == CNT_MAX);
    stable_next = stable_reg;
    cnt_next    = '0;
    if (accept_o) begin
      stable_next = sync2_reg;
    end else if (mismatch) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // Stability counter and accepted level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
    end
  end

  assign stable_o = stable_reg;

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer. Each channel is independent; accept
// events from all channels on one edge are merged into one change pulse.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int SW_WIDTH        = SW_WIDTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [SW_WIDTH-1:0] sw_raw_i,
  output logic [SW_WIDTH-1:0] sw_o,
  output logic                changed_o,
  output logic [SW_WIDTH-1:0] changed_mask_o
);

  logic [SW_WIDTH-1:0] accept;
  logic                changed_reg;
  logic [SW_WIDTH-1:0] mask_reg;

  generate
    for (genvar gi = 0; gi < SW_WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .raw_i   (sw_raw_i[gi]),
        .stable_o(sw_o[gi]),
        .accept_o(accept[gi])
      );
    end
  endgenerate

  // Register the accept strobes on the same edge the stable flops update,
  // so the pulse lines up with the first cycle showing the new sw_o value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      changed_reg <= 1'b0;
      mask_reg    <= '0;
    end else begin
      changed_reg <= |accept;
      mask_reg    <= accept;
    end
  end

  assign changed_o      = changed_reg;
  assign changed_mask_o = mask_reg;

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter SW_WIDTH, default 16: number of switch channels; SHALL equal the width of the switch-controller sw_i port.
REQ-002 Parameter DEBOUNCE_CYCLES, default 100000 (1 ms at 100 MHz): consecutive stable cycles required to accept a level; legal range 2..2^20.
REQ-003 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assertion, active-low.
REQ-005 sw_raw_i  input  SW_WIDTH  raw, asynchronous board switch levels.
REQ-006 sw_o  output  SW_WIDTH  debounced levels; drives sw_i of the switch bus controller.
REQ-007 changed_o  output  1  one-cycle pulse when any sw_o bit changes.
REQ-008 changed_mask_o  output  SW_WIDTH  bits of sw_o that changed; valid only while changed_o=1, otherwise 0.

Function
REQ-009 Each channel SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-010 Each channel SHALL own a counter of width $clog2(DEBOUNCE_CYCLES) and a stable register; sw_o[i] = stable[i], a direct flop output.
REQ-011 Edge where sync2[i] == stable[i]: counter[i] SHALL clear to 0.
REQ-012 Edge where sync2[i] != stable[i] and counter[i] < DEBOUNCE_CYCLES-1: counter[i] SHALL increment by 1.
REQ-013 Edge where sync2[i] != stable[i] and counter[i] == DEBOUNCE_CYCLES-1: stable[i] SHALL take sync2[i] and counter[i] SHALL clear to 0 (accept event).
REQ-014 The counter SHALL never wrap; REQ-013 guarantees it stays at most DEBOUNCE_CYCLES-1.
REQ-015 Latency: a raw level held steady SHALL appear on sw_o at the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples it as edge 1.
REQ-016 A glitch lasting fewer than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change sw_o; when it returns to the stable level, the counter restarts from 0.
REQ-017 Channels SHALL be fully independent; simultaneous accept events on several bits in the same edge SHALL all be reported in one changed_o pulse.
REQ-018 changed_o SHALL be registered: high for exactly the one cycle in which sw_o first shows the new value; changed_mask_o = bits accepted on that edge.
REQ-019 Back-to-back accept events on different bits in consecutive edges SHALL produce consecutive pulses, each carrying only its own mask.

Reset
REQ-020 While rst_ni=0: sync1, sync2, stable, counters, changed_o and changed_mask_o SHALL be 0, independent of clk_i.
REQ-021 Reset mid-count SHALL discard progress; after release with switches high, sw_o SHALL rise DEBOUNCE_CYCLES+2 edges later, with a changed_o pulse.
REQ-022 Release of rst_ni SHALL NOT itself generate changed_o.

Structure
REQ-023 Package sw_debounce_pkg SHALL hold SW_WIDTH_DEFAULT=16 and DEBOUNCE_CYCLES_DEFAULT=100000; the switch bus controller and this block SHALL share SW_WIDTH_DEFAULT.
REQ-024 Single-channel logic (synchronizer, counter, stable flop, accept strobe) SHALL be sub-module debounce_bit, instantiated SW_WIDTH times by a generate loop; changed_o/mask are registered in sw_debounce.

Verification (DEBOUNCE_CYCLES=4, SW_WIDTH=16)
REQ-025 Reset then sw_raw_i=16'h0001 held -> sw_o=16'h0001 at edge 6, changed_o=1 with mask 16'h0001 that cycle only.
REQ-026 sw_raw_i bit0 high for 3 synchronized cycles then low -> sw_o stays 16'h0000, changed_o never asserts.
REQ-027 sw_raw_i 16'h0000 -> 16'hA005 in one edge -> single pulse, mask 16'hA005, sw_o=16'hA005.
REQ-028 bit3 raised one edge after bit2 -> two consecutive pulses, masks 16'h0004 then 16'h0008.
REQ-029 rst_ni low at counter=2 with bit0 high, released -> sw_o=0 during reset, bit0 accepted 6 edges after release, no pulse on release.
REQ-030 Random bounce bursts (<4 cycles) before a steady level -> sw_o equals the reference model each cycle; counters never exceed 3.
